spike_period_encoder: RTL and testbench

Rate-coding spike generator downstream of the reciprocal-period lookup stage. It takes the 8-bit spike period produced per pixel and emits spikes into the SNN input layer over a fixed presentation window of `T_STEPS` timesteps. Per window it emits one spike every `period` timesteps. The value 255, or 0, means "silent".

---
 rtl/spike_period_encoder.sv | 84 ++++++++
 tb/tb_spike_period_encoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_period_encoder.sv
// Rate-coding spike generator: latches a spike period per pixel and emits one
// spike every `per` timesteps across a fixed window of T_STEPS timesteps.
module spike_period_encoder #(
  parameter int T_STEPS = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       period_in,
  input  logic             load,
  input  logic             step,
  output logic             busy,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T_STEPS);

  // Handshake: load and step are single-cycle strobes sampled on the rising
  // edge; load is honoured only in IDLE, step only in RUN, everything else drops.
  logic [1:0]       state;
  logic [7:0]       per;
  logic [7:0]       phase;
  logic [CNT_W-1:0] steps;
  logic [CNT_W-1:0] steps_nxt;
  logic             silent;

  assign steps_nxt = steps + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      per         <= 8'd0;
      phase       <= 8'd0;
      steps       <= '0;
      silent      <= 1'b0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      spike <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            per         <= period_in;
            phase       <= period_in - 8'd1;
            silent      <= (period_in == 8'd0) || (period_in == 8'd255);
            steps       <= '0;
            spike_count <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (step) begin
            steps <= steps_nxt;
            // phase counts down to the step on which the next spike fires
            if (!silent) begin
              if (phase == 8'd0) begin
                spike       <= 1'b1;
                spike_count <= spike_count + 1'b1;
                phase       <= per - 8'd1;
              end else begin
                phase <= phase - 8'd1;
              end
            end
            if (steps_nxt == T_LAST) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spike_period_encoder.sv
// Randomised scenario bench for spike_period_encoder; expected spikes come from
// the arithmetic rule "step k spikes iff k is a multiple of the period".
module tb_spike_period_encoder;

  localparam int T_STEPS = 64;
  localparam int CNT_W   = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       period_in = 8'd0;
  logic             load = 1'b0;
  logic             step = 1'b0;
  logic             busy;
  logic             spike;
  logic [CNT_W-1:0] spike_count;
  logic             done;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int last_cnt = 0;
  logic [CNT_W-1:0] exp_q[$];

  spike_period_encoder #(.T_STEPS(T_STEPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .period_in(period_in), .load(load), .step(step),
    .busy(busy), .spike(spike), .spike_count(spike_count), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full presentation window with period p, checked cycle by cycle.
  task automatic run_window(input int p, input int max_gap, input int stray_at,
                            input bit with_step, input bit load_in_done);
    bit sil;
    int exp_cnt;
    bit exp_spike;
    sil = (p == 0) || (p == 255);
    exp_q.delete();
    if (!sil)
      for (int k = p; k <= T_STEPS; k += p) exp_q.push_back(CNT_W'(k));
    exp_cnt = sil ? 0 : T_STEPS / p;

    load = 1'b1; period_in = 8'(p); step = with_step;
    tick();
    load = 1'b0; step = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || spike !== 1'b0 || spike_count !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL load_accept p=%0d: busy=%b spike=%b cnt=%0d done=%b, need 1 0 0 0",
               p, busy, spike, spike_count, done);
    end

    for (int k = 1; k <= T_STEPS; k++) begin
      for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
        tick();
        n_cmp++;
        if (spike !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL idle_gap p=%0d k=%0d: spike=%b done=%b busy=%b, need 0 0 1",
                   p, k, spike, done, busy);
        end
      end
      step = 1'b1;
      if (k == stray_at) begin
        load = 1'b1; period_in = 8'd5;
      end
      tick();
      step = 1'b0; load = 1'b0;
      exp_spike = (exp_q.size() > 0) && (exp_q[0] == CNT_W'(k));
      if (exp_spike) void'(exp_q.pop_front());
      n_cmp++;
      if (spike !== exp_spike || done !== (k == T_STEPS) || busy !== 1'b1 ||
          spike_count !== CNT_W'(sil ? 0 : k / p)) begin
        n_err++;
        $display("FAIL step p=%0d k=%0d: spike=%b done=%b busy=%b cnt=%0d, need %b %b 1 %0d",
                 p, k, spike, done, busy, spike_count, exp_spike, (k == T_STEPS),
                 sil ? 0 : k / p);
      end
    end

    load = load_in_done; period_in = 8'd7;
    tick();
    load = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || spike !== 1'b0 || spike_count !== CNT_W'(exp_cnt)) begin
      n_err++;
      $display("FAIL window_end p=%0d: busy=%b done=%b spike=%b cnt=%0d, need 0 0 0 %0d",
               p, busy, done, spike, spike_count, exp_cnt);
    end
    last_cnt = exp_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || spike !== 1'b0 || spike_count !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: busy=%b spike=%b cnt=%0d done=%b, need all 0",
               busy, spike, spike_count, done);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_p1();
    run_window(1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_p30();
    run_window(30, 5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_silent();
    run_window(255, 2, 0, 1'b0, 1'b0);
    run_window(0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stray_load();
    run_window(3, 1, 10, 1'b0, 1'b0);
  endtask

  task automatic test_load_with_step();
    run_window(7, 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_load_in_done();
    run_window(6, 2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || spike_count !== CNT_W'(last_cnt)) begin
        n_err++;
        $display("FAIL dropped_load: busy=%b cnt=%0d, need 0 %0d", busy, spike_count, last_cnt);
      end
    end
  endtask

  task automatic test_idle_steps();
    for (int i = 0; i < 10; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      n_cmp++;
      if (spike !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
          spike_count !== CNT_W'(last_cnt)) begin
        n_err++;
        $display("FAIL idle_step %0d: spike=%b done=%b busy=%b cnt=%0d, need 0 0 0 %0d",
                 i, spike, done, busy, spike_count, last_cnt);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; period_in = 8'd4;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || spike !== 1'b0 || spike_count !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b spike=%b cnt=%0d done=%b, need all 0",
               busy, spike, spike_count, done);
    end
    tick();
    run_window(4, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_window($urandom_range(1, 70), 3, 0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_p1();
    tick();
    test_p30();
    tick();
    test_silent();
    tick();
    test_stray_load();
    tick();
    test_load_with_step();
    tick();
    test_load_in_done();
    test_idle_steps();
    test_reset_mid();
    tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
